// File: rtl/exu_mdu_if.sv
// rtl/exu_mdu_if.sv - IDU-side issue and MEM-side result handshake bundle for exu_mdu.
interface exu_mdu_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_i;
  logic [DATA_W-1:0] rega_i;
  logic [DATA_W-1:0] regb_i;
  logic [ADDR_W-1:0] regc_addr_i;
  logic              regc_wr_i;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] regc_data;
  logic [ADDR_W-1:0] regc_addr;
  logic              regc_wr;
  logic [DATA_W-1:0] hi_o;
  logic [DATA_W-1:0] lo_o;
  logic              busy;

  modport slave (
    input  in_valid, op_i, rega_i, regb_i, regc_addr_i, regc_wr_i, out_ready,
    output in_ready, out_valid, regc_data, regc_addr, regc_wr, hi_o, lo_o, busy
  );

  modport master (
    output in_valid, op_i, rega_i, regb_i, regc_addr_i, regc_wr_i, out_ready,
    input  in_ready, out_valid, regc_data, regc_addr, regc_wr, hi_o, lo_o, busy
  );
endinterface

// File: rtl/exu_mdu.sv
// rtl/exu_mdu.sv - execute unit: registered ALU plus iterative MUL/DIV with HI/LO.
// Define EXU_MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU retire in one cycle.
module exu_mdu #(
  parameter  int DATA_W = 32,
  parameter  int ADDR_W = 5,
  localparam int CNT_W  = $clog2(DATA_W) + 1
) (
  input logic      clk,
  input logic      rst_n,
  exu_mdu_if.slave bus
);

  localparam int               SH_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t              state, state_nxt;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   opnd;
  logic [2*DATA_W-1:0] acc;
  logic                neg_q;
  logic [DATA_W-1:0]   hi, lo, res_data;
  logic [ADDR_W-1:0]   res_addr;
  logic                res_wr;

  logic                in_rdy, accept, last;
  logic                is_md, mul_op, signed_op, a_neg, b_neg;
  logic [DATA_W-1:0]   mag_a, mag_b, alu_res;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_step, mul_fin;

  assign in_rdy    = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
  assign accept    = bus.in_valid && in_rdy;
  assign last      = (cnt == LAST);
  assign is_md     = (bus.op_i >= 4'd10) && (bus.op_i <= 4'd13);
  assign mul_op    = (bus.op_i == 4'd10) || (bus.op_i == 4'd11);
  assign signed_op = (bus.op_i == 4'd10) || (bus.op_i == 4'd12);
  assign a_neg     = signed_op && bus.rega_i[DATA_W-1];
  assign b_neg     = signed_op && bus.regb_i[DATA_W-1];
  assign mag_a     = a_neg ? -bus.rega_i : bus.rega_i;
  assign mag_b     = b_neg ? -bus.regb_i : bus.regb_i;

  always_comb begin
    alu_res = '0;
    case (bus.op_i)
      4'd0:    alu_res = bus.rega_i + bus.regb_i;
      4'd1:    alu_res = bus.rega_i - bus.regb_i;
      4'd2:    alu_res = bus.rega_i & bus.regb_i;
      4'd3:    alu_res = bus.rega_i | bus.regb_i;
      4'd4:    alu_res = bus.rega_i ^ bus.regb_i;
      4'd5:    alu_res = bus.regb_i << bus.rega_i[SH_W-1:0];
      4'd6:    alu_res = bus.regb_i >> bus.rega_i[SH_W-1:0];
      4'd7:    alu_res = $signed(bus.regb_i) >>> bus.rega_i[SH_W-1:0];
      4'd8:    alu_res = {{(DATA_W-1){1'b0}}, (bus.rega_i < bus.regb_i)};
      4'd9:    alu_res = {{(DATA_W-1){1'b0}}, ($signed(bus.rega_i) < $signed(bus.regb_i))};
      4'd14:   alu_res = hi;
      4'd15:   alu_res = lo;
      default: alu_res = '0;
    endcase
  end

  // acc = {partial product, remaining multiplier}; opnd holds the multiplicand magnitude
  assign mul_sum  = {1'b0, acc[2*DATA_W-1:DATA_W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_step = {mul_sum, acc[DATA_W-1:1]};
  assign mul_fin  = neg_q ? -mul_step : mul_step;

`ifdef EXU_MDU_DIV_EN
  logic                neg_r, div0;
  logic [DATA_W-1:0]   dividend;
  logic [DATA_W:0]     div_rsh, div_diff;
  logic [2*DATA_W-1:0] div_step;
  logic [DATA_W-1:0]   div_q, div_r;

  // acc = {partial remainder, dividend bits shifting out / quotient bits shifting in}
  assign div_rsh  = acc[2*DATA_W-1:DATA_W-1];
  assign div_diff = div_rsh - {1'b0, opnd};
  assign div_step = div_diff[DATA_W] ? {div_rsh[DATA_W-1:0], acc[DATA_W-2:0], 1'b0}
                                     : {div_diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
  assign div_q    = div0 ? '1 : (neg_q ? -div_step[DATA_W-1:0] : div_step[DATA_W-1:0]);
  assign div_r    = div0 ? dividend
                         : (neg_r ? -div_step[2*DATA_W-1:DATA_W] : div_step[2*DATA_W-1:DATA_W]);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          if (mul_op) state_nxt = S_MUL;
`ifdef EXU_MDU_DIV_EN
          else if (is_md) state_nxt = S_DIV;
`endif
          else state_nxt = S_DONE;
        end else if (state == S_DONE && bus.out_ready) begin
          state_nxt = S_IDLE;
        end
      end
      S_MUL, S_DIV: if (last) state_nxt = S_DONE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      opnd     <= '0;
      acc      <= '0;
      neg_q    <= 1'b0;
      hi       <= '0;
      lo       <= '0;
      res_data <= '0;
      res_addr <= '0;
      res_wr   <= 1'b0;
`ifdef EXU_MDU_DIV_EN
      neg_r    <= 1'b0;
      div0     <= 1'b0;
      dividend <= '0;
`endif
    end else if (accept) begin
      res_addr <= bus.regc_addr_i;
      if (is_md) begin
        // MUL/DIV never write the register file; regc_data shows LO once done
        cnt      <= '0;
        res_wr   <= 1'b0;
        res_data <= '0;
        neg_q    <= a_neg ^ b_neg;
        opnd     <= mul_op ? mag_a : mag_b;
        acc      <= {{DATA_W{1'b0}}, (mul_op ? mag_b : mag_a)};
`ifdef EXU_MDU_DIV_EN
        neg_r    <= a_neg;
        div0     <= (bus.regb_i == '0);
        dividend <= bus.rega_i;
`endif
      end else begin
        res_data <= alu_res;
        res_wr   <= bus.regc_wr_i;
      end
    end else if (state == S_MUL) begin
      cnt <= cnt + CNT_W'(1);
      acc <= mul_step;
      if (last) begin
        hi       <= mul_fin[2*DATA_W-1:DATA_W];
        lo       <= mul_fin[DATA_W-1:0];
        res_data <= mul_fin[DATA_W-1:0];
      end
`ifdef EXU_MDU_DIV_EN
    end else if (state == S_DIV) begin
      cnt <= cnt + CNT_W'(1);
      acc <= div_step;
      if (last) begin
        hi       <= div_r;
        lo       <= div_q;
        res_data <= div_q;
      end
`endif
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state == S_MUL) || (state == S_DIV);
  assign bus.regc_data = res_data;
  assign bus.regc_addr = res_addr;
  assign bus.regc_wr   = res_wr;
  assign bus.hi_o      = hi;
  assign bus.lo_o      = lo;

endmodule

// File: tb/tb_exu_mdu.sv
// tb/tb_exu_mdu.sv - directed bench for exu_mdu (32-bit and 16-bit instances).
module tb_exu_mdu;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n;

  always #5 clk = ~clk;

  exu_mdu_if #(.DATA_W(32), .ADDR_W(5)) b32 ();
  exu_mdu_if #(.DATA_W(16), .ADDR_W(5)) b16 ();

  exu_mdu #(.DATA_W(32), .ADDR_W(5)) dut   (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  exu_mdu #(.DATA_W(16), .ADDR_W(5)) dut16 (.clk(clk), .rst_n(rst_n), .bus(b16.slave));

  logic [3:0]  v_op  [11] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd9};
  logic [31:0] v_a   [11] = '{32'hFFFFFFFF, 32'd5, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0,
                              32'h24, 32'd8, 32'd4, 32'd1, 32'd1, 32'hFFFFFFFF};
  logic [31:0] v_b   [11] = '{32'd1, 32'd7, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                              32'h13, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1};
  logic [31:0] v_exp [11] = '{32'h0, 32'hFFFFFFFE, 32'hF000F000, 32'hFFF0FFF0, 32'h0FF00FF0,
                              32'h130, 32'h00800000, 32'hF8000000, 32'd1, 32'd0, 32'd1};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] addr, input logic wr);
    b32.in_valid    = 1'b1;
    b32.op_i        = op;
    b32.rega_i      = a;
    b32.regb_i      = b;
    b32.regc_addr_i = addr;
    b32.regc_wr_i   = wr;
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!b32.out_valid && cycles < 200) begin
      tick();
      cycles++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    b32.in_valid  = 1'b0;
    b32.out_ready = 1'b1;
    b16.in_valid  = 1'b0;
    b16.out_ready = 1'b1;
    b16.op_i      = 4'd0;
    b16.rega_i    = '0;
    b16.regb_i    = '0;
    b16.regc_addr_i = '0;
    b16.regc_wr_i = 1'b0;
    tick();
    tick();
    chk("rst_out_valid", b32.out_valid, 0);
    chk("rst_regc_data", b32.regc_data, 0);
    chk("rst_regc_wr", b32.regc_wr, 0);
    chk("rst_hi_lo", {b32.hi_o, b32.lo_o}, 0);
    chk("rst_busy", b32.busy, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", b32.in_ready, 1);

    // ALU table issued back-to-back: each op is accepted while the previous result is in DONE
    for (int i = 0; i < 11; i++) begin
      drive(v_op[i], v_a[i], v_b[i], 5'(i + 3), 1'b1);
      tick();
      chk($sformatf("alu%0d_valid", i), b32.out_valid, 1);
      chk($sformatf("alu%0d_data", i), b32.regc_data, v_exp[i]);
      chk($sformatf("alu%0d_addr", i), b32.regc_addr, 5'(i + 3));
      chk($sformatf("alu%0d_wr", i), b32.regc_wr, 1);
    end
    b32.in_valid = 1'b0;
    tick();
    chk("alu_back_idle", b32.out_valid, 0);

    drive(4'd10, 32'hFFFFFFFD, 32'd7, 5'd9, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    chk("mult_busy", b32.busy, 1);
    chk("mult_in_ready", b32.in_ready, 0);
    wait_done(n);
    chk("mult_latency", n, 32);
    chk("mult_hi", b32.hi_o, 32'hFFFFFFFF);
    chk("mult_lo", b32.lo_o, 32'hFFFFFFEB);
    chk("mult_data", b32.regc_data, 32'hFFFFFFEB);
    chk("mult_wr", b32.regc_wr, 0);
    chk("mult_busy_done", b32.busy, 0);
    tick();

    drive(4'd15, 32'd0, 32'd0, 5'd4, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    chk("mflo_data", b32.regc_data, 32'hFFFFFFEB);
    tick();

`ifdef EXU_MDU_DIV_EN
    drive(4'd12, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    wait_done(n);
    chk("div_latency", n, 32);
    chk("div_lo", b32.lo_o, 32'hFFFFFFFD);
    chk("div_hi", b32.hi_o, 32'hFFFFFFFF);
    chk("div_wr", b32.regc_wr, 0);
    tick();
    drive(4'd13, 32'd100, 32'd0, 5'd5, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    wait_done(n);
    chk("divz_latency", n, 32);
    chk("divz_lo", b32.lo_o, 32'hFFFFFFFF);
    chk("divz_hi", b32.hi_o, 32'd100);
    tick();
    drive(4'd14, 32'd0, 32'd0, 5'd6, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    chk("mfhi_data", b32.regc_data, 32'd100);
    tick();
    drive(4'd12, 32'h80000000, 32'hFFFFFFFF, 5'd5, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    wait_done(n);
    chk("divmin_lo", b32.lo_o, 32'h80000000);
    chk("divmin_hi", b32.hi_o, 32'h0);
    tick();
`else
    drive(4'd12, 32'hFFFFFFF9, 32'd2, 5'd5, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    chk("div_off_valid", b32.out_valid, 1);
    chk("div_off_busy", b32.busy, 0);
    chk("div_off_hi_lo", {b32.hi_o, b32.lo_o}, 64'hFFFFFFFF_FFFFFFEB);
    chk("div_off_data", b32.regc_data, 0);
    chk("div_off_wr", b32.regc_wr, 0);
    tick();
    drive(4'd14, 32'd0, 32'd0, 5'd6, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    chk("mfhi_data", b32.regc_data, 32'hFFFFFFFF);
    tick();
`endif

    // Backpressure: the pending SUB must wait until the SRA result is taken
    drive(4'd7, 32'd4, 32'h80000000, 5'd7, 1'b1);
    tick();
    b32.out_ready = 1'b0;
    drive(4'd1, 32'd10, 32'd3, 5'd8, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("bp%0d_data", i), b32.regc_data, 32'hF8000000);
      chk($sformatf("bp%0d_in_ready", i), b32.in_ready, 0);
      chk($sformatf("bp%0d_valid", i), b32.out_valid, 1);
    end
    b32.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", b32.in_ready, 1);
    tick();
    b32.in_valid = 1'b0;
    chk("bp_sub_valid", b32.out_valid, 1);
    chk("bp_sub_data", b32.regc_data, 32'd7);
    chk("bp_sub_addr", b32.regc_addr, 5'd8);
    tick();

    drive(4'd11, 32'h00012345, 32'h00006789, 5'd2, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    repeat (10) tick();
    chk("abort_busy_before", b32.busy, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_hi_lo", {b32.hi_o, b32.lo_o}, 0);
    chk("abort_out_valid", b32.out_valid, 0);
    chk("abort_busy", b32.busy, 0);
    chk("abort_in_ready", b32.in_ready, 1);
    #2;
    rst_n = 1'b1;
    drive(4'd0, 32'd2, 32'd3, 5'd1, 1'b1);
    tick();
    b32.in_valid = 1'b0;
    chk("post_abort_valid", b32.out_valid, 1);
    chk("post_abort_data", b32.regc_data, 32'd5);
    tick();

    b16.op_i = 4'd11;
    b16.rega_i = 16'hFFFF;
    b16.regb_i = 16'hFFFF;
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
    n = 0;
    while (!b16.out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("w16_mult_latency", n, 16);
    chk("w16_mult_hi", b16.hi_o, 16'hFFFE);
    chk("w16_mult_lo", b16.lo_o, 16'h0001);
    tick();

    b16.op_i = 4'd13;
    b16.rega_i = 16'hFFFF;
    b16.regb_i = 16'h0100;
    b16.in_valid = 1'b1;
    tick();
    b16.in_valid = 1'b0;
`ifdef EXU_MDU_DIV_EN
    n = 0;
    while (!b16.out_valid && n < 200) begin
      tick();
      n++;
    end
    chk("w16_div_latency", n, 16);
    chk("w16_div_hi_lo", {b16.hi_o, b16.lo_o}, 32'h00FF_00FF);
`else
    chk("w16_div_valid", b16.out_valid, 1);
    chk("w16_div_hi_lo", {b16.hi_o, b16.lo_o}, 32'hFFFE_0001);
`endif
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
